usb_tx_scheduler: RTL and testbench

- Sequences and arbitrates the USB full-speed packet encoder between two requesters:
  - the receive-side handshake generator (ACK/NAK/STALL);
  - the endpoint data path (DATA0/DATA1 payloads read from a byte buffer).
- Owns the encoder's reset (one packet per reset release), pid, byte_in and last_byte.
- Tracks per-endpoint data toggles and enforces a minimum inter-packet gap.

---
 rtl/usb_tx_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_usb_tx_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: arbitrates handshake and data packets onto the full-speed
// packet encoder, owns the encoder's reset/pid/byte/last_byte interface,
// tracks per-endpoint DATA0/DATA1 toggles and enforces the inter-packet gap.
module usb_tx_scheduler #(
   parameter int unsigned NUM_EP     = 4,
   parameter int unsigned EP_W       = 2,
   parameter int unsigned MAX_LEN    = 64,
   parameter int unsigned LEN_W      = 7,
   parameter int unsigned IPG_CYCLES = 16
) (
   input  logic             clk48,
   input  logic             reset,
   input  logic             hs_req,
   input  logic [1:0]       hs_code,
   output logic             hs_grant,
   input  logic             data_req,
   input  logic [EP_W-1:0]  data_ep,
   input  logic [LEN_W-1:0] data_len,
   output logic             data_grant,
   output logic [LEN_W-1:0] rd_addr,
   input  logic [7:0]       rd_data,
   input  logic             host_ack,
   input  logic [EP_W-1:0]  host_ack_ep,
   input  logic             toggle_clr,
   input  logic [EP_W-1:0]  toggle_clr_ep,
   output logic             enc_reset,
   output logic [3:0]       enc_pid,
   output logic [7:0]       enc_byte,
   output logic             enc_last_byte,
   input  logic             enc_byte_ack,
   input  logic             enc_done,
   output logic             tx_busy,
   output logic             tx_done
);

   // Gap counter is loaded with IPG_CYCLES-1 and leaves GAP as it reaches zero.
   localparam int unsigned GAP_W = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;

   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               enc_reset_nxt;
   logic [3:0]         pid_nxt;
   logic [LEN_W-1:0]   pkt_len;
   logic [LEN_W-1:0]   len_nxt;
   logic [LEN_W-1:0]   idx;
   logic [LEN_W-1:0]   idx_nxt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [GAP_W-1:0]   gap_nxt;
   logic               busy_nxt;
   logic               done_nxt;

   logic [NUM_EP-1:0]  toggle;
   logic [NUM_EP-1:0]  toggle_nxt;

   logic [3:0]         hs_pid;
   logic [3:0]         data_pid;
   logic [LEN_W-1:0]   data_len_clamped;
   logic               data_tog;

   // Encoder byte path: payload comes straight from the buffer, index is the read address.
   assign enc_byte      = rd_data;
   assign rd_addr       = idx;
   assign enc_last_byte = ((state == LOAD) || (state == SEND)) && (idx == pkt_len);

   // Request decode: handshake PID, clamped data length, current toggle of data_ep.
   always_comb begin
      hs_pid = PID_STALL;
      if (hs_code == 2'd0) begin
         hs_pid = PID_ACK;
      end else if (hs_code == 2'd1) begin
         hs_pid = PID_NAK;
      end

      data_len_clamped = (data_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : data_len;

      data_tog = 1'b0;
      for (int unsigned e = 0; e < NUM_EP; e++) begin
         if (data_ep == EP_W'(e)) begin
            data_tog = toggle[e];
         end
      end
      data_pid = data_tog ? PID_DATA1 : PID_DATA0;
   end

   // Packet sequencer: next state, grants and next values of the encoder controls.
   always_comb begin
      state_nxt     = state;
      enc_reset_nxt = enc_reset;
      pid_nxt       = enc_pid;
      len_nxt       = pkt_len;
      idx_nxt       = idx;
      gap_nxt       = gap_cnt;
      busy_nxt      = tx_busy;
      done_nxt      = 1'b0;
      hs_grant      = 1'b0;
      data_grant    = 1'b0;

      case (state)
         IDLE: begin
            // Handshake wins; a concurrent data request simply stays pending.
            if (!reset && (hs_req || data_req)) begin
               hs_grant   = hs_req;
               data_grant = !hs_req;
               pid_nxt    = hs_req ? hs_pid : data_pid;
               len_nxt    = hs_req ? LEN_W'(0) : data_len_clamped;
               idx_nxt    = LEN_W'(0);
               busy_nxt   = 1'b1;
               state_nxt  = LOAD;
            end
         end
         GAP: begin
            if (gap_cnt <= GAP_W'(1)) begin
               gap_nxt   = GAP_W'(0);
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap_cnt - GAP_W'(1);
            end
         end
         LOAD: begin
            // Byte 0 is valid in the buffer by now; release the encoder.
            enc_reset_nxt = 1'b0;
            state_nxt     = SEND;
         end
         SEND: begin
            if (enc_done) begin
               enc_reset_nxt = 1'b1;
               busy_nxt      = 1'b0;
               done_nxt      = 1'b1;
               gap_nxt       = GAP_W'(IPG_CYCLES - 1);
               state_nxt     = GAP;
            end else if (enc_byte_ack && (idx != pkt_len)) begin
               idx_nxt = idx + LEN_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Sequencer state and registered encoder controls.
   always_ff @(posedge clk48) begin
      if (reset) begin
         state     <= IDLE;
         enc_reset <= 1'b1;
         enc_pid   <= 4'd0;
         pkt_len   <= LEN_W'(0);
         idx       <= LEN_W'(0);
         gap_cnt   <= GAP_W'(0);
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_nxt;
         enc_reset <= enc_reset_nxt;
         enc_pid   <= pid_nxt;
         pkt_len   <= len_nxt;
         idx       <= idx_nxt;
         gap_cnt   <= gap_nxt;
         tx_busy   <= busy_nxt;
         tx_done   <= done_nxt;
      end
   end

   // Toggle update: clear beats flip on the same endpoint; out-of-range endpoints never match.
   always_comb begin
      toggle_nxt = toggle;
      for (int unsigned e = 0; e < NUM_EP; e++) begin
         if (toggle_clr && (toggle_clr_ep == EP_W'(e))) begin
            toggle_nxt[e] = 1'b0;
         end else if (host_ack && (host_ack_ep == EP_W'(e))) begin
            toggle_nxt[e] = ~toggle[e];
         end
      end
   end

   // Per-endpoint data toggle state, DATA0 after reset.
   always_ff @(posedge clk48) begin
      if (reset) begin
         toggle <= '0;
      end else begin
         toggle <= toggle_nxt;
      end
   end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Testbench for usb_tx_scheduler: a behavioural encoder/buffer model drives the
// DUT while a toggle/PID/length model derived from the packet rules predicts results.
module tb_usb_tx_scheduler;

   localparam int unsigned NUM_EP     = 4;
   localparam int unsigned EP_W       = 2;
   localparam int unsigned MAX_LEN    = 64;
   localparam int unsigned LEN_W      = 7;
   localparam int unsigned IPG_CYCLES = 16;

   logic             clk48 = 1'b0;
   logic             reset;
   logic             hs_req;
   logic [1:0]       hs_code;
   logic             hs_grant;
   logic             data_req;
   logic [EP_W-1:0]  data_ep;
   logic [LEN_W-1:0] data_len;
   logic             data_grant;
   logic [LEN_W-1:0] rd_addr;
   logic [7:0]       rd_data;
   logic             host_ack;
   logic [EP_W-1:0]  host_ack_ep;
   logic             toggle_clr;
   logic [EP_W-1:0]  toggle_clr_ep;
   logic             enc_reset;
   logic [3:0]       enc_pid;
   logic [7:0]       enc_byte;
   logic             enc_last_byte;
   logic             enc_byte_ack;
   logic             enc_done;
   logic             tx_busy;
   logic             tx_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:127];
   bit         tmodel [NUM_EP];
   logic [7:0] got_q [$];

   usb_tx_scheduler #(
      .NUM_EP(NUM_EP), .EP_W(EP_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IPG_CYCLES(IPG_CYCLES)
   ) dut (
      .clk48(clk48), .reset(reset),
      .hs_req(hs_req), .hs_code(hs_code), .hs_grant(hs_grant),
      .data_req(data_req), .data_ep(data_ep), .data_len(data_len), .data_grant(data_grant),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .host_ack(host_ack), .host_ack_ep(host_ack_ep),
      .toggle_clr(toggle_clr), .toggle_clr_ep(toggle_clr_ep),
      .enc_reset(enc_reset), .enc_pid(enc_pid), .enc_byte(enc_byte),
      .enc_last_byte(enc_last_byte), .enc_byte_ack(enc_byte_ack), .enc_done(enc_done),
      .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk48 = ~clk48;

   // Payload buffer: one-cycle read latency.
   always @(posedge clk48) rd_data <= mem[rd_addr];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk48);
      #1;
   endtask

   // Reference PID from the packet rules and the bench's toggle model.
   function automatic logic [3:0] exp_pid(input bit hs, input logic [1:0] code, input logic [EP_W-1:0] ep);
      if (hs) begin
         if (code == 2'd0) return 4'b0010;
         if (code == 2'd1) return 4'b1010;
         return 4'b1110;
      end
      return tmodel[ep] ? 4'b1011 : 4'b0011;
   endfunction

   task automatic apply_toggle(input bit ack, input logic [EP_W-1:0] aep, input bit clr, input logic [EP_W-1:0] cep);
      host_ack = ack; host_ack_ep = aep; toggle_clr = clr; toggle_clr_ep = cep;
      tick();
      host_ack = 1'b0; toggle_clr = 1'b0;
      if (clr) tmodel[cep] = 1'b0;
      if (ack && !(clr && (cep == aep))) tmodel[aep] = !tmodel[aep];
   endtask

   // Raise a request and hold it until granted; returns in the cycle after the grant.
   task automatic request(input bit hs, input logic [1:0] code, input logic [EP_W-1:0] ep,
                          input logic [LEN_W-1:0] len, output bit got, output bit wrong, output int waited);
      hs_req = hs; hs_code = code; data_req = !hs; data_ep = ep; data_len = len;
      got = 1'b0; wrong = 1'b0; waited = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         #1;
         if (hs ? hs_grant : data_grant) got = 1'b1;
         if (hs ? data_grant : hs_grant) wrong = 1'b1;
         tick();
         if (!got) waited++;
      end
      hs_req = 1'b0; data_req = 1'b0;
   endtask

   // Encoder model: take bytes while last_byte is low, up to max_acks.
   task automatic encode(input int max_acks, output int n_acks);
      got_q.delete();
      n_acks = 0;
      while (enc_last_byte === 1'b0 && n_acks < max_acks) begin
         got_q.push_back(enc_byte);
         enc_byte_ack = 1'b1;
         tick();
         enc_byte_ack = 1'b0;
         n_acks++;
         tick();
         tick();
      end
   endtask

   task automatic finish_packet(output logic td_pre, output logic td, output logic busy, output logic rst);
      td_pre = tx_done;
      enc_done = 1'b1;
      tick();
      enc_done = 1'b0;
      td = tx_done; busy = tx_busy; rst = enc_reset;
   endtask

   task automatic run_data(input logic [EP_W-1:0] ep, input logic [LEN_W-1:0] len, input int max_acks,
                           output bit got, output logic [3:0] pid, output int n_acks,
                           output logic lb_end, output logic td);
      bit wrong; int w; logic a, b, c;
      request(1'b0, 2'd0, ep, len, got, wrong, w);
      tick();
      pid = enc_pid;
      encode(max_acks, n_acks);
      lb_end = enc_last_byte;
      finish_packet(a, td, b, c);
   endtask

   task automatic test_reset();
      reset = 1'b1; hs_req = 1'b1; data_req = 1'b1;
      tick(); tick(); tick();
      checks++; if (enc_reset !== 1'b1) begin errors++; $display("FAIL rst_enc_reset: got %b expected 1", enc_reset); end
      checks++; if (enc_pid !== 4'd0) begin errors++; $display("FAIL rst_enc_pid: got %b expected 0000", enc_pid); end
      checks++; if (enc_last_byte !== 1'b0) begin errors++; $display("FAIL rst_last_byte: got %b expected 0", enc_last_byte); end
      checks++; if (rd_addr !== 7'd0) begin errors++; $display("FAIL rst_rd_addr: got %0d expected 0", rd_addr); end
      checks++; if ({hs_grant, data_grant} !== 2'b00) begin errors++; $display("FAIL rst_grants: got %b expected 00", {hs_grant, data_grant}); end
      checks++; if ({tx_busy, tx_done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b expected 00", {tx_busy, tx_done}); end
      hs_req = 1'b0; data_req = 1'b0; reset = 1'b0;
      tick();
   endtask

   task automatic test_handshake();
      bit got, wrong; int w; logic pre, td, busy, rst;
      request(1'b1, 2'd1, 2'd0, 7'd0, got, wrong, w);
      checks++; if (!got || wrong) begin errors++; $display("FAIL hs_grant: got %b/%b expected 1/0", got, wrong); end
      checks++; if ({enc_reset, tx_busy} !== 2'b11) begin errors++; $display("FAIL hs_load: got reset,busy=%b expected 11", {enc_reset, tx_busy}); end
      tick();
      checks++; if (enc_reset !== 1'b0) begin errors++; $display("FAIL hs_enc_reset_low: got %b expected 0", enc_reset); end
      checks++; if (enc_pid !== exp_pid(1'b1, 2'd1, 2'd0)) begin errors++; $display("FAIL hs_pid: got %b expected %b", enc_pid, exp_pid(1'b1, 2'd1, 2'd0)); end
      checks++; if (enc_last_byte !== 1'b1) begin errors++; $display("FAIL hs_last_byte: got %b expected 1", enc_last_byte); end
      enc_byte_ack = 1'b1; tick(); enc_byte_ack = 1'b0; tick();
      checks++; if (rd_addr !== 7'd0 || enc_last_byte !== 1'b1) begin errors++; $display("FAIL hs_no_advance: got addr %0d lb %b expected 0/1", rd_addr, enc_last_byte); end
      finish_packet(pre, td, busy, rst);
      checks++; if ({pre, td, busy, rst} !== 4'b0101) begin errors++; $display("FAIL hs_done: got pre,done,busy,rst=%b expected 0101", {pre, td, busy, rst}); end
      tick();
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL hs_done_pulse: got %b expected 0", tx_done); end
   endtask

   task automatic test_data_payload();
      bit got, wrong; int w, n; logic pre, td, busy, rst;
      logic [7:0] eb [3];
      logic [3:0] e;
      eb = '{8'hA5, 8'h01, 8'hFF};
      for (int i = 0; i < 3; i++) mem[i] = eb[i];
      e = exp_pid(1'b0, 2'd0, 2'd2);
      request(1'b0, 2'd0, 2'd2, 7'd3, got, wrong, w);
      checks++; if (!got || wrong) begin errors++; $display("FAIL data_grant: got %b/%b expected 1/0", got, wrong); end
      tick();
      checks++; if (enc_pid !== e) begin errors++; $display("FAIL data_pid: got %b expected %b", enc_pid, e); end
      encode(10, n);
      checks++; if (n !== 3) begin errors++; $display("FAIL data_ack_count: got %0d expected 3", n); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++; if (got_q[i] !== eb[i]) begin errors++; $display("FAIL data_byte%0d: got %h expected %h", i, got_q[i], eb[i]); end
      end
      enc_byte_ack = 1'b1; tick(); enc_byte_ack = 1'b0; tick();
      checks++; if (rd_addr !== 7'd3 || enc_last_byte !== 1'b1) begin errors++; $display("FAIL data_saturate: got addr %0d lb %b expected 3/1", rd_addr, enc_last_byte); end
      finish_packet(pre, td, busy, rst);
      checks++; if (td !== 1'b1) begin errors++; $display("FAIL data_tx_done: got %b expected 1", td); end
   endtask

   task automatic test_toggles();
      bit got; int n; logic lb, td; logic [3:0] pid, e;
      apply_toggle(1'b1, 2'd2, 1'b0, 2'd0);
      e = exp_pid(1'b0, 2'd0, 2'd2);
      run_data(2'd2, 7'd0, 4, got, pid, n, lb, td);
      checks++; if (!got || pid !== e) begin errors++; $display("FAIL tog_ack: got %b expected %b", pid, e); end
      apply_toggle(1'b1, 2'd2, 1'b1, 2'd2);
      e = exp_pid(1'b0, 2'd0, 2'd2);
      run_data(2'd2, 7'd0, 4, got, pid, n, lb, td);
      checks++; if (!got || pid !== e) begin errors++; $display("FAIL tog_clr_wins: got %b expected %b", pid, e); end
      apply_toggle(1'b1, 2'd2, 1'b0, 2'd0);
      apply_toggle(1'b1, 2'd1, 1'b0, 2'd0);
      e = exp_pid(1'b0, 2'd0, 2'd2);
      run_data(2'd2, 7'd0, 4, got, pid, n, lb, td);
      checks++; if (!got || pid !== e) begin errors++; $display("FAIL tog_other_ep: got %b expected %b", pid, e); end
      e = exp_pid(1'b0, 2'd0, 2'd1);
      run_data(2'd1, 7'd0, 4, got, pid, n, lb, td);
      checks++; if (!got || pid !== e) begin errors++; $display("FAIL tog_ep1: got %b expected %b", pid, e); end
   endtask

   task automatic test_arb_gap();
      bit hs_seen, d_early, g; int k, dg_k; logic pre, td, busy, rst; logic [3:0] e;
      hs_req = 1'b1; hs_code = 2'd2; data_req = 1'b1; data_ep = 2'd1; data_len = 7'd0;
      hs_seen = 1'b0; d_early = 1'b0;
      for (int i = 0; i < 200 && !hs_seen; i++) begin
         #1;
         if (data_grant) d_early = 1'b1;
         if (hs_grant) hs_seen = 1'b1;
         tick();
      end
      hs_req = 1'b0;
      checks++; if (!hs_seen || d_early) begin errors++; $display("FAIL arb_priority: got hs %b data %b expected 1/0", hs_seen, d_early); end
      tick();
      checks++; if (enc_pid !== 4'b1110) begin errors++; $display("FAIL arb_hs_pid: got %b expected 1110", enc_pid); end
      finish_packet(pre, td, busy, rst);
      k = 1; dg_k = 0;
      while (enc_reset === 1'b1 && k < 100) begin
         #1;
         g = data_grant;
         if (g && dg_k == 0) dg_k = k;
         tick();
         k++;
         if (g) data_req = 1'b0;
      end
      data_req = 1'b0;
      checks++; if (k !== int'(IPG_CYCLES) + 2) begin errors++; $display("FAIL gap_reset_low: got %0d cycles expected %0d", k, IPG_CYCLES + 2); end
      checks++; if (dg_k !== int'(IPG_CYCLES)) begin errors++; $display("FAIL gap_grant: got cycle %0d expected %0d", dg_k, IPG_CYCLES); end
      e = exp_pid(1'b0, 2'd0, 2'd1);
      checks++; if (enc_pid !== e) begin errors++; $display("FAIL arb_data_pid: got %b expected %b", enc_pid, e); end
      finish_packet(pre, td, busy, rst);
   endtask

   task automatic test_limits();
      bit got, wrong; int w, n; logic lb, td, pre, busy, rst; logic [3:0] pid, e;
      e = exp_pid(1'b0, 2'd0, 2'd0);
      run_data(2'd0, 7'd0, 4, got, pid, n, lb, td);
      checks++; if (!got || pid !== e || n !== 0 || lb !== 1'b1) begin errors++; $display("FAIL zero_len: got pid %b acks %0d lb %b expected %b/0/1", pid, n, lb, e); end
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      request(1'b0, 2'd0, 2'd3, 7'd100, got, wrong, w);
      tick();
      encode(80, n);
      checks++; if (n !== int'(MAX_LEN)) begin errors++; $display("FAIL clamp_count: got %0d expected %0d", n, MAX_LEN); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== mem[i]) begin errors++; $display("FAIL clamp_byte%0d: got %h expected %h", i, got_q[i], mem[i]); end
      end
      enc_byte_ack = 1'b1; tick(); enc_byte_ack = 1'b0; tick();
      checks++; if (rd_addr !== 7'd64) begin errors++; $display("FAIL clamp_addr: got %0d expected 64", rd_addr); end
      finish_packet(pre, td, busy, rst);
      checks++; if (td !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b expected 1", td); end
   endtask

   task automatic test_reset_mid();
      bit got, wrong; int w, n; logic lb, td; logic [3:0] pid, e;
      apply_toggle(1'b1, 2'd3, 1'b0, 2'd0);
      e = exp_pid(1'b0, 2'd0, 2'd3);
      request(1'b0, 2'd0, 2'd3, 7'd5, got, wrong, w);
      tick();
      checks++; if (enc_pid !== e) begin errors++; $display("FAIL mid_pid: got %b expected %b", enc_pid, e); end
      encode(2, n);
      reset = 1'b1; host_ack = 1'b1; host_ack_ep = 2'd0;
      tick();
      reset = 1'b0; host_ack = 1'b0;
      for (int i = 0; i < int'(NUM_EP); i++) tmodel[i] = 1'b0;
      checks++; if ({enc_reset, tx_busy, tx_done, enc_last_byte} !== 4'b1000) begin errors++; $display("FAIL mid_ctrl: got rst,busy,done,lb=%b expected 1000", {enc_reset, tx_busy, tx_done, enc_last_byte}); end
      checks++; if (enc_pid !== 4'd0 || rd_addr !== 7'd0) begin errors++; $display("FAIL mid_pid_addr: got %b/%0d expected 0000/0", enc_pid, rd_addr); end
      enc_done = 1'b1; tick(); enc_done = 1'b0;
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b expected 0", tx_done); end
      e = exp_pid(1'b0, 2'd0, 2'd3);
      run_data(2'd3, 7'd0, 4, got, pid, n, lb, td);
      checks++; if (!got || pid !== e) begin errors++; $display("FAIL mid_after_ep3: got %b expected %b", pid, e); end
      e = exp_pid(1'b0, 2'd0, 2'd0);
      run_data(2'd0, 7'd0, 4, got, pid, n, lb, td);
      checks++; if (!got || pid !== e) begin errors++; $display("FAIL mid_after_ep0: got %b expected %b", pid, e); end
   endtask

   task automatic test_random();
      bit got, wrong, hs; int w, n, n_exp; logic pre, td, busy, rst;
      logic [1:0] code; logic [EP_W-1:0] ep; logic [LEN_W-1:0] len; logic [3:0] e;
      for (int it = 0; it < 16; it++) begin
         if ($urandom_range(0, 1) == 1)
            apply_toggle(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
         hs   = ($urandom_range(0, 3) == 0);
         code = 2'($urandom);
         ep   = 2'($urandom);
         len  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(65, 127)) : 7'($urandom_range(0, 12));
         for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
         e     = exp_pid(hs, code, ep);
         n_exp = hs ? 0 : ((int'(len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(len));
         request(hs, code, ep, len, got, wrong, w);
         checks++; if (!got || wrong) begin errors++; $display("FAIL rnd%0d_grant: got %b/%b expected 1/0", it, got, wrong); end
         if ($urandom_range(0, 1) == 1) apply_toggle(1'b1, ep, 1'b0, 2'd0);
         else tick();
         checks++; if (enc_pid !== e) begin errors++; $display("FAIL rnd%0d_pid: got %b expected %b", it, enc_pid, e); end
         encode(n_exp + 2, n);
         checks++; if (n !== n_exp || enc_last_byte !== 1'b1) begin errors++; $display("FAIL rnd%0d_len: got %0d lb %b expected %0d/1", it, n, enc_last_byte, n_exp); end
         for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== mem[i]) begin errors++; $display("FAIL rnd%0d_byte%0d: got %h expected %h", it, i, got_q[i], mem[i]); end
         end
         finish_packet(pre, td, busy, rst);
         checks++; if ({td, busy, rst} !== 3'b101) begin errors++; $display("FAIL rnd%0d_done: got done,busy,rst=%b expected 101", it, {td, busy, rst}); end
      end
   endtask

   initial begin
      reset = 1'b1; hs_req = 1'b0; hs_code = 2'd0; data_req = 1'b0; data_ep = '0; data_len = '0;
      host_ack = 1'b0; host_ack_ep = '0; toggle_clr = 1'b0; toggle_clr_ep = '0;
      enc_byte_ack = 1'b0; enc_done = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 8'(i);
      for (int i = 0; i < int'(NUM_EP); i++) tmodel[i] = 1'b0;
      test_reset();
      test_handshake();
      test_data_payload();
      test_toggles();
      test_arb_gap();
      test_limits();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
